argon_lsu: RTL and testbench

- Parametrised load/store unit for the Argon multi-cycle core. Replaces direct core-driven memory address/mask/data lines with a request/ready handshake to memory.
- Handles byte/half/word sizing, byte-lane steering, and sign/zero extension of loads.
- Detects misaligned accesses and bounds memory wait states with a timeout.
- Sits between the control FSM (MEM stage) and the memory port; instruction fetch still uses its own path.

---
 rtl/argon_pkg.sv | 48 ++++
 rtl/argon_lsu_if.sv | 24 ++
 rtl/argon_lsu_extract.sv | 24 ++
 rtl/argon_lsu.sv | 132 +++++++++++++
 tb/tb_argon_lsu.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/argon_pkg.sv
// Shared Argon definitions: access-size encodings, memory lane masks and the LSU state type.
package argon_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    localparam logic [2:0] RDMASK_NONE = 3'b000;
    localparam logic [2:0] RDMASK_B    = 3'b001;
    localparam logic [2:0] RDMASK_H    = 3'b010;
    localparam logic [2:0] RDMASK_W    = 3'b100;

    localparam logic [1:0] WRMASK_NONE = 2'b00;
    localparam logic [1:0] WRMASK_B    = 2'b01;
    localparam logic [1:0] WRMASK_H    = 2'b10;
    localparam logic [1:0] WRMASK_W    = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} lsu_state_e;

    // Size 3 is reserved and is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_SZ_B: is_misaligned = 1'b0;
            MEM_SZ_H: is_misaligned = lane[0];
            MEM_SZ_W: is_misaligned = (lane != 2'b00);
            default:  is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] rd_mask_of(input logic [1:0] size);
        case (size)
            MEM_SZ_B: rd_mask_of = RDMASK_B;
            MEM_SZ_H: rd_mask_of = RDMASK_H;
            MEM_SZ_W: rd_mask_of = RDMASK_W;
            default:  rd_mask_of = RDMASK_NONE;
        endcase
    endfunction

    function automatic logic [1:0] wr_mask_of(input logic [1:0] size);
        case (size)
            MEM_SZ_B: wr_mask_of = WRMASK_B;
            MEM_SZ_H: wr_mask_of = WRMASK_H;
            MEM_SZ_W: wr_mask_of = WRMASK_W;
            default:  wr_mask_of = WRMASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/argon_lsu_if.sv
// Memory-port bundle between the Argon LSU (master) and the data memory (slave).
interface argon_lsu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [XLEN-1:0]   o_mem_wr_data;
    logic [2:0]        o_mem_rd_mask;
    logic [1:0]        o_mem_wr_mask;
    logic              i_mem_ready;
    logic [XLEN-1:0]   i_mem_rd_data;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wr_data, o_mem_rd_mask, o_mem_wr_mask,
        input  i_mem_ready, i_mem_rd_data
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wr_data, o_mem_rd_mask, o_mem_wr_mask,
        output i_mem_ready, i_mem_rd_data
    );
endinterface

// File: rtl/argon_lsu_extract.sv
// Load-data extraction: shift the addressed lane down, truncate to size, sign/zero extend.
module argon_lsu_extract
    import argon_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rd_data,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            is_signed,
    output logic [XLEN-1:0] ext_data
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted  = rd_data >> {lane, 3'b000};
        ext_data = shifted;
        case (size)
            MEM_SZ_B: ext_data = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
            MEM_SZ_H: ext_data = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
            default:  ext_data = shifted;
        endcase
    end
endmodule

// File: rtl/argon_lsu.sv
// Argon load/store unit: sized, lane-steered memory access over a req/ready handshake.
// Define ARGON_LSU_TIMEOUT_EN to bound REQ to WAIT_MAX cycles; otherwise REQ waits forever.
module argon_lsu
    import argon_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              sys_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misaligned,
    output logic              o_timeout,
    argon_lsu_if.master       mem
);
    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
        $error("argon_lsu: WAIT_MAX must be in 1..255");
    end

    lsu_state_e        state_q, state_d;
    logic              we_q, signed_q;
    logic [1:0]        size_q, lane;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, rdata_q, ext_data;
    logic              timeout_hit;

    assign lane = addr_q[1:0];

`ifdef ARGON_LSU_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q;

    assign timeout_hit = (state_q == StReq) && !mem.i_mem_ready &&
                         (wait_cnt_q == 8'(WAIT_MAX - 1));

    always_comb begin
        wait_cnt_d = 8'd0;
        if (state_q == StReq && !mem.i_mem_ready && !timeout_hit) wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_hit;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (i_req) state_d = is_misaligned(i_size, i_addr[1:0]) ? StErr : StReq;
            StReq: begin
                if (mem.i_mem_ready) state_d = StResp;
                else if (timeout_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= MEM_SZ_B;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && i_req) begin
                we_q     <= i_we;
                signed_q <= i_signed;
                size_q   <= i_size;
                addr_q   <= i_addr;
                wdata_q  <= i_wdata;
            end
            // Stores leave o_rdata holding the last load result.
            if (state_q == StReq && mem.i_mem_ready && !we_q) rdata_q <= ext_data;
        end
    end

    argon_lsu_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .rd_data  (mem.i_mem_rd_data),
        .lane     (lane),
        .size     (size_q),
        .is_signed(signed_q),
        .ext_data (ext_data)
    );

    always_comb begin
        mem.o_mem_req     = 1'b0;
        mem.o_mem_we      = 1'b0;
        mem.o_mem_addr    = '0;
        mem.o_mem_wr_data = '0;
        mem.o_mem_rd_mask = RDMASK_NONE;
        mem.o_mem_wr_mask = WRMASK_NONE;
        if (state_q == StReq) begin
            mem.o_mem_req     = 1'b1;
            mem.o_mem_we      = we_q;
            mem.o_mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
            mem.o_mem_wr_data = wdata_q << {lane, 3'b000};
            mem.o_mem_rd_mask = we_q ? RDMASK_NONE : rd_mask_of(size_q);
            mem.o_mem_wr_mask = we_q ? wr_mask_of(size_q) : WRMASK_NONE;
        end
    end

    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StResp);
    assign o_misaligned = (state_q == StErr);
    assign o_rdata      = rdata_q;
endmodule

// File: tb/tb_argon_lsu.sv
// Self-checking bench for argon_lsu: directed scenarios plus randomized accesses vs. a model.
module tb_argon_lsu;
    localparam int unsigned WAIT_MAX = 4;

    logic        sys_clk = 1'b0;
    logic        i_reset;
    logic        i_req, i_we, i_signed;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_misaligned, o_timeout;
    logic [31:0] o_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata = 32'h0;

    argon_lsu_if #(.XLEN(32), .ADDR_W(32)) mem_bus ();

    argon_lsu #(
        .XLEN(32), .ADDR_W(32), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .sys_clk     (sys_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_misaligned(o_misaligned),
        .o_timeout   (o_timeout),
        .mem         (mem_bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(o_busy), 32'h0);
        check({tag, " done"}, 32'(o_done), 32'h0);
        check({tag, " rdata"}, o_rdata, 32'h0);
        check({tag, " misaligned"}, 32'(o_misaligned), 32'h0);
        check({tag, " timeout"}, 32'(o_timeout), 32'h0);
        check({tag, " mem_req"}, 32'(mem_bus.o_mem_req), 32'h0);
        check({tag, " mem_we"}, 32'(mem_bus.o_mem_we), 32'h0);
        check({tag, " rd_mask"}, 32'(mem_bus.o_mem_rd_mask), 32'h0);
        check({tag, " wr_mask"}, 32'(mem_bus.o_mem_wr_mask), 32'h0);
    endtask

    // Reference result of a load: pick the addressed bytes and extend them.
    function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sg);
        int bits;
        logic [31:0] m, v;
        bits = 8 << sz;
        m = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        v = (rd >> (8 * lane)) & m;
        if (sg && bits < 32 && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    // One complete access starting in IDLE; memory raises ready after wait_n stalled cycles.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int wait_n);
        bit mis;
        mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        i_req = 1'b1; i_we = we; i_size = sz; i_signed = sg; i_addr = addr; i_wdata = wd;
        tick();
        i_req = 1'b0;
        if (mis) begin
            mem_bus.i_mem_ready = 1'b1;
            check("mis pulse", 32'(o_misaligned), 32'h1);
            check("mis mem_req", 32'(mem_bus.o_mem_req), 32'h0);
            check("mis done", 32'(o_done), 32'h0);
            tick();
            mem_bus.i_mem_ready = 1'b0;
            check("mis pulse end", 32'(o_misaligned), 32'h0);
            check("mis idle", 32'(o_busy), 32'h0);
            check("mis no done", 32'(o_done), 32'h0);
            check("mis no req", 32'(mem_bus.o_mem_req), 32'h0);
            return;
        end
        for (int c = 0; c <= wait_n; c++) begin
`ifdef ARGON_LSU_TIMEOUT_EN
            if (c == int'(WAIT_MAX)) begin
                check("timeout pulse", 32'(o_timeout), 32'h1);
                check("timeout mem_req", 32'(mem_bus.o_mem_req), 32'h0);
                check("timeout idle", 32'(o_busy), 32'h0);
                check("timeout done", 32'(o_done), 32'h0);
                tick();
                check("timeout pulse end", 32'(o_timeout), 32'h0);
                return;
            end
`endif
            check("mem_req", 32'(mem_bus.o_mem_req), 32'h1);
            check("busy", 32'(o_busy), 32'h1);
            check("mem_addr", mem_bus.o_mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_we", 32'(mem_bus.o_mem_we), 32'(we));
            check("rd_mask", 32'(mem_bus.o_mem_rd_mask), we ? 32'h0 : (32'd1 << sz));
            check("wr_mask", 32'(mem_bus.o_mem_wr_mask), we ? 32'(sz) + 32'd1 : 32'h0);
            check("wr_data", mem_bus.o_mem_wr_data, wd << (8 * addr[1:0]));
            check("done early", 32'(o_done), 32'h0);
            if (c == wait_n) begin
                mem_bus.i_mem_ready = 1'b1;
                mem_bus.i_mem_rd_data = rd;
            end
            tick();
            mem_bus.i_mem_ready = 1'b0;
            mem_bus.i_mem_rd_data = $urandom;
        end
        if (!we) model_rdata = load_value(rd, addr[1:0], sz, sg);
        check("done", 32'(o_done), 32'h1);
        check("rdata", o_rdata, model_rdata);
        check("timeout none", 32'(o_timeout), 32'h0);
        tick();
        check("done pulse end", 32'(o_done), 32'h0);
        check("idle after", 32'(o_busy), 32'h0);
        check("rdata held", o_rdata, model_rdata);
    endtask

    initial begin
        logic [1:0] sz;
        logic [31:0] a;
        i_reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_size = 2'd0; i_signed = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        mem_bus.i_mem_ready = 1'b0; mem_bus.i_mem_rd_data = 32'h0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        check_all_zero("post reset");

        // Signed byte load from lane 3, ready on first REQ cycle
        run_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        check("lb signed value", o_rdata, 32'hFFFF_FF80);

        // Half store to lane 2 with one stall cycle
        run_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 1);
        check("store keeps rdata", o_rdata, 32'hFFFF_FF80);

        // Misaligned word load
        run_access(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0);

        // Long stall: times out with the macro, completes after 20 cycles without it
        run_access(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'hCAFE_F00D, 20);

        // Unsigned half load from lane 2
        run_access(1'b0, 2'd1, 1'b0, 32'h4002, 32'h0, 32'h8001_0000, 0);
        check("lhu value", o_rdata, 32'h0000_8001);

        // Request during REQ is ignored; reset mid-REQ clears everything at once
        i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_signed = 1'b0; i_addr = 32'h6000;
        tick();
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h7004; i_wdata = 32'h1111_2222;
        tick();
        i_req = 1'b0;
        check("busy req ignored addr", mem_bus.o_mem_addr, 32'h6000);
        check("busy req ignored we", 32'(mem_bus.o_mem_we), 32'h0);
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("mid reset");
        tick();
        i_reset = 1'b0;
        model_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("after reset quiet done", 32'(o_done), 32'h0);
            check("after reset quiet timeout", 32'(o_timeout), 32'h0);
            check("after reset quiet busy", 32'(o_busy), 32'h0);
        end
        run_access(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 32'h1234_5678, 2);
        check("post reset lw", o_rdata, 32'h1234_5678);

        // Randomized accesses, mostly aligned, short stalls
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            run_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                       $urandom, int'($urandom_range(0, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
